// File: rtl/ula_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    MULT   = 2'b01,
    DIV    = 2'b10,
    FIM    = 2'b11
  } state_e;

endpackage

// File: rtl/ula_muldiv_somador_n.sv
// W-bit adder with carry-in/carry-out; the iterative unit uses it both for the
// shift-add product step and for the restoring-division trial subtraction.
module somador_n #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers. Signed operations
// iterate on magnitudes and apply the result signs when the last bit is done.
module ula_muldiv
  import ula_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inicio,
  input  logic [2:0]   operacao,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO,
  output logic         ocupado,
  output logic         pronto,
  output logic         divZero
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   shf_q, shf_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           negLo_q, negLo_d;
  logic           negHi_q, negHi_d;
  logic           dz_q, dz_d;

  op_e            op;
  logic           isSigned;
  logic [N-1:0]   magA, magB;
  logic [N:0]     addA, addB, addSum;
  logic           addCin, addCout;
  logic [2*N-1:0] prod;

  assign op       = op_e'(operacao);
  assign isSigned = (op == OP_MULT) || (op == OP_DIV);
  assign magA     = (isSigned && SrcA[N-1]) ? -SrcA : SrcA;
  assign magB     = (isSigned && SrcB[N-1]) ? -SrcB : SrcB;

  // Multiply adds the multiplicand when the current multiplier bit is set;
  // divide subtracts the divisor from the shifted partial remainder.
  always_comb begin
    addA   = {1'b0, acc_q};
    addB   = shf_q[0] ? {1'b0, opnd_q} : '0;
    addCin = 1'b0;
    if (state_q == DIV) begin
      addA   = {acc_q, shf_q[N-1]};
      addB   = ~{1'b0, opnd_q};
      addCin = 1'b1;
    end
  end

  somador_n #(
    .W(N + 1)
  ) u_somador (
    .a_i   (addA),
    .b_i   (addB),
    .cin_i (addCin),
    .sum_o (addSum),
    .cout_o(addCout)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    negLo_d = negLo_q;
    negHi_d = negHi_q;
    dz_d    = dz_q;
    prod    = '0;

    case (state_q)
      OCIOSO, FIM: begin
        if (state_q == FIM) state_d = OCIOSO;
        if (inicio) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d   = '0;
              shf_d   = magB;
              opnd_d  = magA;
              negLo_d = isSigned && (SrcA[N-1] ^ SrcB[N-1]);
              negHi_d = 1'b0;
              cnt_d   = CW'(N);
              dz_d    = 1'b0;
              state_d = MULT;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor skips iteration and leaves HI/LO untouched.
              if (SrcB == '0) begin
                dz_d    = 1'b1;
                state_d = FIM;
              end else begin
                acc_d   = '0;
                shf_d   = magA;
                opnd_d  = magB;
                negLo_d = isSigned && (SrcA[N-1] ^ SrcB[N-1]);
                negHi_d = isSigned && SrcA[N-1];
                cnt_d   = CW'(N);
                dz_d    = 1'b0;
                state_d = DIV;
              end
            end
            OP_MTHI: begin
              hi_d    = SrcA;
              dz_d    = 1'b0;
              state_d = FIM;
            end
            OP_MTLO: begin
              lo_d    = SrcA;
              dz_d    = 1'b0;
              state_d = FIM;
            end
            default: ;
          endcase
        end
      end

      MULT: begin
        acc_d = addSum[N:1];
        shf_d = {addSum[0], shf_q[N-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod = {acc_d, shf_d};
          if (negLo_q) prod = -prod;
          hi_d    = prod[2*N-1:N];
          lo_d    = prod[N-1:0];
          state_d = FIM;
        end
      end

      DIV: begin
        if (addCout) begin
          acc_d = addSum[N-1:0];
          shf_d = {shf_q[N-2:0], 1'b1};
        end else begin
          acc_d = addA[N-1:0];
          shf_d = {shf_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          lo_d    = negLo_q ? -shf_d : shf_d;
          hi_d    = negHi_q ? -acc_d : acc_d;
          state_d = FIM;
        end
      end

      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OCIOSO;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      shf_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      negLo_q <= 1'b0;
      negHi_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      negLo_q <= negLo_d;
      negHi_q <= negHi_d;
      dz_q    <= dz_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign ocupado = (state_q == MULT) || (state_q == DIV);
  assign pronto  = (state_q == FIM);
  assign divZero = (state_q == FIM) && dz_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// Directed self-checking bench for ula_muldiv (N=32) with hand-computed results.
module tb_ula_muldiv;

  localparam logic [2:0] C_MULT  = 3'b000;
  localparam logic [2:0] C_MULTU = 3'b001;
  localparam logic [2:0] C_DIV   = 3'b010;
  localparam logic [2:0] C_DIVU  = 3'b011;
  localparam logic [2:0] C_MTHI  = 3'b100;
  localparam logic [2:0] C_MTLO  = 3'b101;
  localparam logic [2:0] C_RSVD  = 3'b110;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inicio;
  logic [2:0]  operacao;
  logic [31:0] SrcA, SrcB;
  logic [31:0] HI, LO;
  logic        ocupado, pronto, divZero;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ula_muldiv #(.N(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .inicio  (inicio),
    .operacao(operacao),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .HI      (HI),
    .LO      (LO),
    .ocupado (ocupado),
    .pronto  (pronto),
    .divZero (divZero)
  );

  // Issues one operation and observes 40 cycles; operands are scrambled after
  // the start cycle so results must come from the latched values.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int pCycle, output int pCount, output int bCount,
                        output int bLast, output logic [31:0] rHi, output logic [31:0] rLo,
                        output logic rDz, output logic holdOk);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = HI; lo0 = LO;
    inicio = 1'b1; operacao = op; SrcA = a; SrcB = b;
    pCycle = -1; pCount = 0; bCount = 0; bLast = 0;
    rHi = '0; rLo = '0; rDz = 1'b0; holdOk = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      inicio = 1'b0; SrcA = 32'hDEADBEEF; SrcB = 32'h0BADF00D;
      if (ocupado) begin
        bCount++; bLast = k;
        if (HI !== hi0 || LO !== lo0) holdOk = 1'b0;
      end
      if (pronto) begin
        if (pCount == 0) begin pCycle = k; rHi = HI; rLo = LO; rDz = divZero; end
        pCount++;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; inicio = 1'b0; operacao = 3'b0; SrcA = '0; SrcB = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin fails++;
      $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", HI, LO); end
    checks++; if ({ocupado, pronto, divZero} !== 3'b000) begin fails++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {ocupado, pronto, divZero}); end
    reset_n = 1'b1; inicio = 1'b1; operacao = C_MTLO; SrcA = 32'hA5A5A5A5;
    @(negedge clk);
    inicio = 1'b0;
    checks++; if (pronto !== 1'b1 || LO !== 32'hA5A5A5A5 || HI !== 32'h0) begin fails++;
      $display("[TB] FAIL first_start: got pronto=%b LO=%h HI=%h expected 1/a5a5a5a5/0", pronto, LO, HI); end
    @(negedge clk);
    checks++; if (pronto !== 1'b0) begin fails++;
      $display("[TB] FAIL fim_exit: got pronto=%b expected 0", pronto); end
  endtask

  task automatic test_mult;
    int pc, pn, bc, bl; logic [31:0] h, l; logic dz, ok;
    run_op(C_MULT, 32'hFFFFFFFF, 32'h2, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFE) begin fails++;
      $display("[TB] FAIL mult_neg: got %h_%h expected ffffffff_fffffffe", h, l); end
    checks++; if (pc !== 33 || pn !== 1) begin fails++;
      $display("[TB] FAIL mult_pronto: got cycle %0d count %0d expected 33/1", pc, pn); end
    checks++; if (bc !== 32 || bl !== 32) begin fails++;
      $display("[TB] FAIL mult_busy: got %0d cycles last %0d expected 32/32", bc, bl); end
    checks++; if (ok !== 1'b1 || dz !== 1'b0) begin fails++;
      $display("[TB] FAIL mult_hold: got hold=%b dz=%b expected 1/0", ok, dz); end
    run_op(C_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (h !== 32'h0 || l !== 32'hF) begin fails++;
      $display("[TB] FAIL mult_negneg: got %h_%h expected 00000000_0000000f", h, l); end
  endtask

  task automatic test_multu;
    int pc, pn, bc, bl; logic [31:0] h, l; logic dz, ok;
    run_op(C_MULTU, 32'hFFFFFFFF, 32'h2, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (h !== 32'h1 || l !== 32'hFFFFFFFE) begin fails++;
      $display("[TB] FAIL multu_big: got %h_%h expected 00000001_fffffffe", h, l); end
    run_op(C_MULTU, 32'h12345678, 32'h10, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (h !== 32'h1 || l !== 32'h23456780) begin fails++;
      $display("[TB] FAIL multu_shift: got %h_%h expected 00000001_23456780", h, l); end
    checks++; if (pc !== 33 || ok !== 1'b1) begin fails++;
      $display("[TB] FAIL multu_timing: got cycle %0d hold %b expected 33/1", pc, ok); end
  endtask

  task automatic test_divu;
    int pc, pn, bc, bl; logic [31:0] h, l; logic dz, ok;
    run_op(C_DIVU, 32'd7, 32'd2, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (l !== 32'd3 || h !== 32'd1) begin fails++;
      $display("[TB] FAIL divu_7_2: got LO=%h HI=%h expected 3/1", l, h); end
    checks++; if (pc !== 33 || bc !== 32 || dz !== 1'b0) begin fails++;
      $display("[TB] FAIL divu_timing: got cycle %0d busy %0d dz %b expected 33/32/0", pc, bc, dz); end
    run_op(C_DIVU, 32'hFFFFFFFF, 32'h10, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (l !== 32'h0FFFFFFF || h !== 32'hF) begin fails++;
      $display("[TB] FAIL divu_big: got LO=%h HI=%h expected 0fffffff/f", l, h); end
  endtask

  task automatic test_div_signed;
    int pc, pn, bc, bl; logic [31:0] h, l; logic dz, ok;
    run_op(C_DIV, 32'hFFFFFFF9, 32'd2, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin fails++;
      $display("[TB] FAIL div_neg7_2: got LO=%h HI=%h expected fffffffd/ffffffff", l, h); end
    run_op(C_DIV, 32'd7, 32'hFFFFFFFE, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (l !== 32'hFFFFFFFD || h !== 32'h1) begin fails++;
      $display("[TB] FAIL div_7_neg2: got LO=%h HI=%h expected fffffffd/1", l, h); end
    run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (l !== 32'h80000000 || h !== 32'h0 || dz !== 1'b0) begin fails++;
      $display("[TB] FAIL div_minneg: got LO=%h HI=%h dz=%b expected 80000000/0/0", l, h, dz); end
  endtask

  task automatic test_mthi_divzero;
    int pc, pn, bc, bl; logic [31:0] h, l; logic dz, ok;
    run_op(C_MTHI, 32'h12345678, 32'h0, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (pc !== 1 || h !== 32'h12345678 || l !== 32'h80000000) begin fails++;
      $display("[TB] FAIL mthi: got cycle %0d HI=%h LO=%h expected 1/12345678/80000000", pc, h, l); end
    run_op(C_DIV, 32'h55, 32'h0, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (pc !== 1 || dz !== 1'b1 || bc !== 0) begin fails++;
      $display("[TB] FAIL div_zero_flag: got cycle %0d dz %b busy %0d expected 1/1/0", pc, dz, bc); end
    checks++; if (h !== 32'h12345678 || l !== 32'h80000000) begin fails++;
      $display("[TB] FAIL div_zero_hold: got HI=%h LO=%h expected 12345678/80000000", h, l); end
    run_op(C_MTLO, 32'hCAFEF00D, 32'h0, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (pc !== 1 || l !== 32'hCAFEF00D || h !== 32'h12345678 || dz !== 1'b0) begin fails++;
      $display("[TB] FAIL mtlo: got cycle %0d LO=%h HI=%h dz=%b expected 1/cafef00d/12345678/0", pc, l, h, dz); end
    run_op(C_RSVD, 32'hFFFF, 32'h1, pc, pn, bc, bl, h, l, dz, ok);
    checks++; if (pn !== 0 || bc !== 0 || HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin fails++;
      $display("[TB] FAIL reserved: got pronto %0d busy %0d HI=%h LO=%h expected 0/0/12345678/cafef00d", pn, bc, HI, LO); end
  endtask

  task automatic test_abort;
    int pn, bn;
    @(negedge clk);
    inicio = 1'b1; operacao = C_MULT; SrcA = 32'h1234; SrcB = 32'h5678;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (k == 5) begin inicio = 1'b1; operacao = C_MTHI; SrcA = 32'h55555555; end
      if (k == 6) begin
        checks++; if (ocupado !== 1'b1 || HI !== 32'h12345678) begin fails++;
          $display("[TB] FAIL busy_ignore: got ocupado=%b HI=%h expected 1/12345678", ocupado, HI); end
      end
    end
    reset_n = 1'b0;
    #1;
    checks++; if (HI !== 32'h0 || LO !== 32'h0 || ocupado !== 1'b0 || pronto !== 1'b0) begin fails++;
      $display("[TB] FAIL abort_reset: got HI=%h LO=%h ocupado=%b pronto=%b expected 0/0/0/0", HI, LO, ocupado, pronto); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    pn = 0; bn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pronto) pn++;
      if (ocupado) bn++;
    end
    checks++; if (pn !== 0 || bn !== 0 || HI !== 32'h0 || LO !== 32'h0) begin fails++;
      $display("[TB] FAIL abort_quiet: got pronto %0d busy %0d HI=%h LO=%h expected 0/0/0/0", pn, bn, HI, LO); end
  endtask

  task automatic test_back_to_back;
    int pn, issueK, p2K;
    logic [31:0] h1, l1, h2, l2;
    pn = 0; issueK = -1; p2K = -1;
    h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    @(negedge clk);
    inicio = 1'b1; operacao = C_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (pronto) begin
        pn++;
        if (issueK < 0) begin
          h1 = HI; l1 = LO; issueK = k;
          inicio = 1'b1; operacao = C_MULTU; SrcA = 32'h10000; SrcB = 32'h10000;
        end else if (p2K < 0) begin
          h2 = HI; l2 = LO; p2K = k;
        end
      end
    end
    checks++; if (l1 !== 32'd14 || h1 !== 32'd2) begin fails++;
      $display("[TB] FAIL b2b_divu: got LO=%h HI=%h expected e/2", l1, h1); end
    checks++; if (h2 !== 32'h1 || l2 !== 32'h0) begin fails++;
      $display("[TB] FAIL b2b_multu: got %h_%h expected 00000001_00000000", h2, l2); end
    checks++; if (pn !== 2 || issueK !== 33 || p2K !== 66) begin fails++;
      $display("[TB] FAIL b2b_pronto: got count %0d at %0d/%0d expected 2 at 33/66", pn, issueK, p2K); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_divu();
    test_div_signed();
    test_mthi_divzero();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ula_muldiv.md
ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inicio  input  1  start request, sampled on clk.
REQ-005 SHALL have operacao  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 SHALL have SrcA, SrcB  input  N each  operands (multiplicand/dividend A, multiplier/divisor B).
REQ-007 SHALL have HI, LO  output  N each  architectural result registers.
REQ-008 SHALL have ocupado  output  1  operation in progress.
REQ-009 SHALL have pronto  output  1  one-cycle completion pulse.
REQ-010 SHALL have divZero  output  1  divide-by-zero flag, valid only with pronto.

Function
REQ-011 FSM states OCIOSO, MULT, DIV, FIM; ocupado = 1 only in MULT or DIV.
REQ-012 inicio SHALL be accepted only when ocupado = 0 (OCIOSO or FIM); ignored while ocupado = 1; reserved codes ignored, no state change.
REQ-013 Accepted MULT/MULTU/DIV/DIVU SHALL latch SrcA/SrcB in the start cycle; later operand changes have no effect.
REQ-014 MULT/MULTU: shift-add, one multiplier bit per cycle, N iteration cycles; {HI,LO} = 2N-bit product.
REQ-015 DIV/DIVU: restoring division, one quotient bit per cycle, N iteration cycles; LO = quotient, HI = remainder.
REQ-016 Signed ops SHALL run on magnitudes and fix signs on completion: product negative iff signs differ; quotient truncates toward zero; remainder takes dividend's sign.
REQ-017 Signed DIV of most-negative by -1 SHALL give LO = most-negative, HI = 0, divZero = 0.
REQ-018 Latency: start accepted at edge 0 -> HI/LO updated and pronto = 1 in cycle N+1 (FIM state), pronto low otherwise.
REQ-019 HI/LO SHALL hold previous values throughout MULT/DIV and update only on entry to FIM.
REQ-020 DIV/DIVU with SrcB = 0: no iteration; FIM next cycle with pronto = 1, divZero = 1, HI/LO unchanged.
REQ-021 MTHI/MTLO SHALL write SrcA into HI/LO at the accepting edge; FIM next cycle with pronto = 1; other register unchanged.
REQ-022 inicio in FIM SHALL be accepted (back-to-back); otherwise FIM returns to OCIOSO after one cycle.
REQ-023 Iteration counter SHALL be ceil(log2(N+1)) bits, exhausting exactly after N iterations, no wrap.

Reset
REQ-024 reset_n = 0 SHALL immediately force OCIOSO, HI = 0, LO = 0, ocupado = 0, pronto = 0, divZero = 0, aborting any operation with no partial result written.
REQ-025 After reset_n deasserts, first inicio SHALL be accepted on the next rising edge.

Structure
REQ-026 Package ula_pkg SHALL hold the operacao encoding enum and FSM state enum.
REQ-027 One sub-module somador_n (N+1-bit adder/subtractor with carry-in, carry-out) SHALL be shared by multiply add and divide trial-subtract steps.

Verification
REQ-028 N=32, MULT 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, pronto in cycle 33 only, ocupado cycles 1-32.
REQ-029 MULTU 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; DIVU 7/2 -> LO=3, HI=1.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 MTHI 0x12345678 then DIV x/0 -> pronto cycle 1, divZero=1, HI still 0x12345678.
REQ-032 MULT started, inicio re-pulsed at cycle 5 and reset_n low at cycle 10 -> second start ignored; after reset HI=LO=0, ocupado=0, no pronto.
REQ-033 Back-to-back: new MULTU issued in FIM cycle of a DIVU -> accepted, correct results for both, pronto once per op.
